ecc_operand_framer: RTL and testbench

//   Parametrised digit-serial front end for the ECC scalar-multiply core (kP over GF(p)).

---
 rtl/ecc_operand_framer.sv | 141 ++++++++++++++
 tb/tb_ecc_operand_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_operand_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ecc_operand_framer : digit-serial operand assembler and launcher for the kP core
// Rev 1.0
// ---------------------------------------------------------------------------
module ecc_operand_framer #(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 4,
  parameter int TIMEOUT = 15000,
  parameter int TO_W    = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] prime,
  input  logic [DIGIT_W-1:0] k,
  input  logic [DIGIT_W-1:0] Px,
  input  logic [DIGIT_W-1:0] Py,
  output logic               o_core_start,
  output logic [WIDTH-1:0]   o_a,
  output logic [WIDTH-1:0]   o_prime,
  output logic [WIDTH-1:0]   o_k,
  output logic [WIDTH-1:0]   o_px,
  output logic [WIDTH-1:0]   o_py,
  input  logic               i_core_done,
  input  logic [WIDTH-1:0]   i_core_x,
  input  logic [WIDTH-1:0]   i_core_y,
  output logic [WIDTH-1:0]   final_output_1,
  output logic [WIDTH-1:0]   final_output_2,
  output logic               final_done,
  output logic               o_err_param,
  output logic               o_timeout,
  output logic               o_busy
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int DC_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DIGITS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [DC_W-1:0] dcnt;
  logic [TO_W-1:0] tcnt;
  logic            shift_en;
  logic            prime_bad;
  logic            to_hit;

  // Digit 0 is captured on the accepting edge, so IDLE also shifts.
  assign shift_en  = ((state == S_IDLE) && i_start) || (state == S_LOAD);
  assign prime_bad = (o_prime[WIDTH-1:1] == '0) || !o_prime[0];
  assign to_hit    = (tcnt == TO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = (DIGITS == 1) ? S_CHECK : S_LOAD;
      S_LOAD:  if (dcnt == DC_LAST) state_nxt = S_CHECK;
      S_CHECK: state_nxt = prime_bad ? S_DONE : S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (i_core_done || to_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_core_start = (state == S_START);
    final_done   = (state == S_DONE);
    o_busy       = (state != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_a            <= '0;
      o_prime        <= '0;
      o_k            <= '0;
      o_px           <= '0;
      o_py           <= '0;
      dcnt           <= '0;
      tcnt           <= '0;
      final_output_1 <= '0;
      final_output_2 <= '0;
      o_err_param    <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      if (shift_en) begin
        o_a     <= WIDTH'({o_a, a});
        o_prime <= WIDTH'({o_prime, prime});
        o_k     <= WIDTH'({o_k, k});
        o_px    <= WIDTH'({o_px, Px});
        o_py    <= WIDTH'({o_py, Py});
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            dcnt           <= DC_W'(1);
            final_output_1 <= '0;
            final_output_2 <= '0;
            o_err_param    <= 1'b0;
            o_timeout      <= 1'b0;
          end
        end
        S_LOAD:  dcnt <= dcnt + 1'b1;
        S_CHECK: if (prime_bad) o_err_param <= 1'b1;
        S_START: tcnt <= '0;
        S_WAIT: begin
          tcnt <= tcnt + 1'b1;
          // A completion on the terminal-count cycle takes priority over the abort.
          if (i_core_done) begin
            final_output_1 <= i_core_x;
            final_output_2 <= i_core_y;
          end else if (to_hit) begin
            o_timeout      <= 1'b1;
            final_output_1 <= '0;
            final_output_2 <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ecc_operand_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ecc_operand_framer : scoreboard bench for ecc_operand_framer (32/4 and 8/2 builds)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ecc_operand_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Build A: 32-bit operands, 4-bit digits, short timeout
  logic        ua_start = 1'b0, ua_cd = 1'b0;
  logic [3:0]  ua_da = '0, ua_dp = '0, ua_dk = '0, ua_dx = '0, ua_dy = '0;
  logic [31:0] ua_cx = '0, ua_cy = '0;
  logic        ua_cs, ua_fd, ua_err, ua_to, ua_busy;
  logic [31:0] ua_oa, ua_op, ua_ok, ua_ox, ua_oy, ua_f1, ua_f2;

  // Build B: 8-bit operands, 2-bit digits
  logic        ub_start = 1'b0, ub_cd = 1'b0;
  logic [1:0]  ub_da = '0, ub_dp = '0, ub_dk = '0, ub_dx = '0, ub_dy = '0;
  logic [7:0]  ub_cx = '0, ub_cy = '0;
  logic        ub_cs, ub_fd, ub_err, ub_to, ub_busy;
  logic [7:0]  ub_oa, ub_op, ub_ok, ub_ox, ub_oy, ub_f1, ub_f2;

  ecc_operand_framer #(.WIDTH(32), .DIGIT_W(4), .TIMEOUT(64), .TO_W(7)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(ua_start),
    .a(ua_da), .prime(ua_dp), .k(ua_dk), .Px(ua_dx), .Py(ua_dy),
    .o_core_start(ua_cs),
    .o_a(ua_oa), .o_prime(ua_op), .o_k(ua_ok), .o_px(ua_ox), .o_py(ua_oy),
    .i_core_done(ua_cd), .i_core_x(ua_cx), .i_core_y(ua_cy),
    .final_output_1(ua_f1), .final_output_2(ua_f2), .final_done(ua_fd),
    .o_err_param(ua_err), .o_timeout(ua_to), .o_busy(ua_busy)
  );

  ecc_operand_framer #(.WIDTH(8), .DIGIT_W(2), .TIMEOUT(64), .TO_W(7)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(ub_start),
    .a(ub_da), .prime(ub_dp), .k(ub_dk), .Px(ub_dx), .Py(ub_dy),
    .o_core_start(ub_cs),
    .o_a(ub_oa), .o_prime(ub_op), .o_k(ub_ok), .o_px(ub_ox), .o_py(ub_oy),
    .i_core_done(ub_cd), .i_core_x(ub_cx), .i_core_y(ub_cy),
    .final_output_1(ub_f1), .final_output_2(ub_f2), .final_done(ub_fd),
    .o_err_param(ub_err), .o_timeout(ub_to), .o_busy(ub_busy)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        err;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input int i, input logic [31:0] va, vp, vk, vx, vy);
    ua_da = va[31-4*i -: 4];
    ua_dp = vp[31-4*i -: 4];
    ua_dk = vk[31-4*i -: 4];
    ua_dx = vx[31-4*i -: 4];
    ua_dy = vy[31-4*i -: 4];
  endtask

  // One job on build A; lat<0 means the core never answers.
  task automatic run_a(input logic [31:0] va, vp, vk, vx, vy, input int lat,
                       input logic [31:0] rx, ry, input logic e_err, e_to);
    int   t0, ts, td, tf;
    exp_t e;
    e.x = (e_err || e_to) ? 32'h0 : rx;
    e.y = (e_err || e_to) ? 32'h0 : ry;
    e.err = e_err;
    e.to  = e_to;
    q.push_back(e);
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      ua_start = (i == 0);
      drive_a(i, va, vp, vk, vx, vy);
    end
    ts = -1; td = -1; tf = -1;
    for (int n = 0; n < 200 && tf < 0; n++) begin
      @(negedge clk);
      ua_start = 1'b0;
      ua_cd    = 1'b0;
      if (ua_cs) begin
        ts = cyc;
        chk("a_op_a", ua_oa, va);
        chk("a_op_prime", ua_op, vp);
        chk("a_op_k", ua_ok, vk);
        chk("a_op_px", ua_ox, vx);
        chk("a_op_py", ua_oy, vy);
      end
      if (ts >= 0 && lat >= 0 && td < 0 && cyc == ts + lat) begin
        ua_cd = 1'b1;
        ua_cx = rx;
        ua_cy = ry;
        td    = cyc;
      end
      if (ua_fd) tf = cyc;
    end
    e = q.pop_front();
    if (tf < 0) begin
      chk("a_final_done_seen", 0, 1);
    end else begin
      chk("a_res_x", ua_f1, e.x);
      chk("a_res_y", ua_f2, e.y);
      chk("a_err_flag", ua_err, e.err);
      chk("a_to_flag", ua_to, e.to);
      chk("a_op_hold", ua_oa, va);
      if (e_err) begin
        chk("a_no_launch", ts < 0, 1);
        chk("a_err_latency", tf - t0, 9);
      end else begin
        chk("a_start_latency", ts - t0, 9);
        if (e_to) chk("a_timeout_latency", tf - (ts + 1), 64);
        else      chk("a_done_latency", tf - td, 1);
      end
      @(negedge clk);
      chk("a_fd_single", ua_fd, 0);
      chk("a_busy_after", ua_busy, 0);
      chk("a_hold_x", ua_f1, e.x);
    end
  endtask

  // Two back-to-back jobs on build B with a stray start during WAIT.
  task automatic run_b();
    logic [7:0] va[2], vp[2], vk[2], vx[2], vy[2];
    logic [7:0] sx, sy;
    int         t0, ts, tf, nst;
    exp_t       e;
    va[0] = 8'h35; vp[0] = 8'h0B; vk[0] = 8'h5A; vx[0] = 8'hC3; vy[0] = 8'h1E;
    va[1] = 8'hC2; vp[1] = 8'hFB; vk[1] = 8'h17; vx[1] = 8'h08; vy[1] = 8'h99;
    for (int j = 0; j < 2; j++) begin
      sx = va[j] + vk[j];
      sy = vx[j] ^ vy[j];
      e.x = {24'h0, sx};
      e.y = {24'h0, sy};
      e.err = 1'b0;
      e.to  = 1'b0;
      q.push_back(e);
      @(negedge clk);
      t0 = cyc;
      if (j == 1) chk("b_busy_gap", ub_busy, 0);
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        if (i == 1) chk("b_busy_load", ub_busy, 1);
        ub_start = (i == 0);
        ub_da = va[j][7-2*i -: 2];
        ub_dp = vp[j][7-2*i -: 2];
        ub_dk = vk[j][7-2*i -: 2];
        ub_dx = vx[j][7-2*i -: 2];
        ub_dy = vy[j][7-2*i -: 2];
      end
      ts = -1; tf = -1; nst = 0;
      for (int n = 0; n < 100 && tf < 0; n++) begin
        @(negedge clk);
        ub_start = 1'b0;
        ub_cd    = 1'b0;
        if (ub_cs) begin
          ts = cyc;
          nst++;
        end
        if (ts >= 0 && cyc == ts + 3) ub_start = 1'b1;
        if (ts >= 0 && cyc == ts + 10) begin
          ub_cd = 1'b1;
          ub_cx = ub_oa + ub_ok;
          ub_cy = ub_ox ^ ub_oy;
        end
        if (ub_fd) begin
          tf = cyc;
          chk("b_busy_done", ub_busy, 1);
        end
      end
      e = q.pop_front();
      if (tf < 0) begin
        chk("b_final_done_seen", 0, 1);
      end else begin
        chk("b_res_x", {24'h0, ub_f1}, e.x);
        chk("b_res_y", {24'h0, ub_f2}, e.y);
        chk("b_flags", {ub_err, ub_to}, 2'b00);
        chk("b_one_launch", nst, 1);
        chk("b_start_latency", ts - t0, 5);
      end
    end
    @(negedge clk);
    chk("b_idle_after", ub_busy, 0);
    chk("b_fd_single", ub_fd, 0);
  endtask

  initial begin
    int nfd;
    @(negedge clk);
    chk("rst_busy", ua_busy, 0);
    chk("rst_fd", ua_fd, 0);
    chk("rst_core_start", ua_cs, 0);
    chk("rst_op_a", ua_oa, 0);
    chk("rst_res", {ua_f1, ua_f2}, 0);
    chk("rst_flags", {ua_err, ua_to}, 0);
    chk("rst_b_busy", ub_busy, 0);
    rst = 1'b0;

    // Curve y^2 = x^3 + 2x + 2 mod 17, P=(5,1), k=2 -> (6,3)
    run_a(32'd2, 32'h11, 32'd2, 32'd5, 32'd1, 20, 32'd6, 32'd3, 1'b0, 1'b0);
    run_a(32'd2, 32'h11, 32'd2, 32'd5, 32'd1, -1, 32'd6, 32'd3, 1'b0, 1'b1);
    run_a(32'd2, 32'h11, 32'd2, 32'd5, 32'd1, 64, 32'd6, 32'd3, 1'b0, 1'b0);
    run_a(32'd2, 32'h10, 32'd2, 32'd5, 32'd1, 20, 32'd6, 32'd3, 1'b1, 1'b0);
    run_a(32'd2, 32'h1,  32'd2, 32'd5, 32'd1, 20, 32'd6, 32'd3, 1'b1, 1'b0);

    // Reset while digit 4 is due
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      ua_start = (i == 0);
      drive_a(i, 32'hDEADBEEF, 32'h11, 32'd2, 32'd5, 32'd1);
    end
    @(negedge clk);
    ua_start = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", ua_busy, 0);
    chk("mid_rst_op_a", ua_oa, 0);
    chk("mid_rst_outs", {ua_fd, ua_cs, ua_err, ua_to}, 0);
    @(negedge clk);
    rst = 1'b0;
    nfd = 0;
    repeat (30) begin
      @(negedge clk);
      if (ua_fd) nfd++;
    end
    chk("mid_rst_no_fd", nfd, 0);
    run_a(32'd2, 32'h11, 32'd2, 32'd5, 32'd1, 20, 32'd6, 32'd3, 1'b0, 1'b0);

    run_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
